// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control sequencer for the mm:ss stopwatch digit counter. It conditions the
// raw buttons and switches, derives the count / adjust / blink timebases and
// runs the RUN / PAUSED / ADJUST mode machine. The digit datapath only ever
// sees clean single-cycle commands.
//
// Ports
//   clk_c       in  1  single clock, rising edge
//   reset_c     in  1  synchronous active-high reset
//   btn_pause   in  1  raw pause button (asynchronous, bouncy)
//   btn_rst     in  1  raw clear button (asynchronous, bouncy)
//   ADJ         in  1  adjust-mode switch (asynchronous)
//   SEL         in  2  digit select: 00 sec_ones, 01 sec_tens, 10 min_ones, 11 min_tens
//   NUM         in  4  value to load into the selected digit
//   cnt_en      out 1  one-cycle pulse, counter advances one second
//   cnt_clr     out 1  one-cycle pulse, counter clears to 00:00
//   adj_we      out 1  one-cycle write strobe for the selected digit
//   adj_sel     out 2  digit index, qualified by adj_we
//   adj_val     out 4  clamped digit value, qualified by adj_we
//   blink_mask  out 4  bit i set blanks digit i this phase
//   mode        out 2  00 RUN, 01 PAUSED, 10 ADJUST
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int DB_CYC    = 1_000_000
) (
    input  logic       clk_c,
    input  logic       reset_c,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       ADJ,
    input  logic [1:0] SEL,
    input  logic [3:0] NUM,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       adj_we,
    output logic [1:0] adj_sel,
    output logic [3:0] adj_val,
    output logic [3:0] blink_mask,
    output logic [1:0] mode
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int AW = $clog2(ADJ_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int DW = $clog2(DB_CYC + 1);

    localparam logic [TW-1:0] TICK_TC  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_TC   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);
    localparam logic [DW-1:0] DB_TC    = DW'(DB_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_ADJUST = 2'b10
    } state_t;

    // Tens digits only go to 5 (mm:ss), ones digits to 9.
    function automatic logic [3:0] clamp_digit(input logic [1:0] sel, input logic [3:0] num);
        logic [3:0] lim;
        lim = sel[0] ? 4'd5 : 4'd9;
        return (num > lim) ? lim : num;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer for every asynchronous input ----
    logic [8:0] sync_p0, sync_p1;

    always_ff @(posedge clk_c) begin
        if (reset_c) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {btn_pause, btn_rst, ADJ, SEL, NUM};
            sync_p1 <= sync_p0;
        end
    end

    logic       adj_s;
    logic [1:0] sel_s;
    logic [3:0] num_s;
    logic [1:0] btn_s;   // [1] pause, [0] clear

    assign btn_s = sync_p1[8:7];
    assign adj_s = sync_p1[6];
    assign sel_s = sync_p1[5:4];
    assign num_s = sync_p1[3:0];

    // ---- stage p2: debounce; level flips after DB_CYC consecutive disagreeing cycles ----
    logic [1:0]    db_lvl, db_lvl_d;
    logic [DW-1:0] db_cnt [2];

    always_ff @(posedge clk_c) begin
        if (reset_c) begin
            db_lvl   <= '0;
            db_lvl_d <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            db_lvl_d <= db_lvl;
            for (int i = 0; i < 2; i++) begin
                if (btn_s[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TC) begin
                    db_lvl[i] <= btn_s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic pause_evt, rst_evt;
    assign pause_evt = db_lvl[1] & ~db_lvl_d[1];
    assign rst_evt   = db_lvl[0] & ~db_lvl_d[0];

    // ---- timebases ----
    state_t        state, state_nxt;
    logic          resume_run, resume_nxt;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          tick_tc, adj_tc;

    assign tick_tc = (tick_cnt == TICK_TC);
    assign adj_tc  = (adj_cnt == ADJ_TC);

    // The tick counter is held at zero outside RUN and on a clear, so the
    // first second after resume or clear is a full TICK_DIV cycles long.
    always_ff @(posedge clk_c) begin
        if (reset_c || state != ST_RUN || rst_evt) tick_cnt <= '0;
        else if (tick_tc)                          tick_cnt <= '0;
        else                                       tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge clk_c) begin
        if (reset_c || state != ST_ADJUST) adj_cnt <= '0;
        else if (adj_tc)                   adj_cnt <= '0;
        else                               adj_cnt <= adj_cnt + AW'(1);
    end

    always_ff @(posedge clk_c) begin
        if (reset_c) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_TC) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    // ---- mode FSM and output next-values ----
    logic       cnt_en_nxt, cnt_clr_nxt, adj_we_nxt;
    logic [1:0] adj_sel_nxt;
    logic [3:0] adj_val_nxt, blink_mask_nxt;

    always_comb begin
        state_nxt  = state;
        resume_nxt = resume_run;
        // ADJ wins over pause; a pause in the entry cycle flips the saved flag.
        unique case (state)
            ST_RUN: begin
                if (adj_s) begin
                    state_nxt  = ST_ADJUST;
                    resume_nxt = ~pause_evt;
                end else if (pause_evt) begin
                    state_nxt  = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj_s) begin
                    state_nxt  = ST_ADJUST;
                    resume_nxt = pause_evt;
                end else if (pause_evt) begin
                    state_nxt  = ST_RUN;
                end
            end
            ST_ADJUST: begin
                if (!adj_s)         state_nxt  = resume_run ? ST_RUN : ST_PAUSED;
                else if (pause_evt) resume_nxt = ~resume_run;
            end
            default: state_nxt = ST_RUN;
        endcase

        // A terminal count in a mode-exit cycle is dropped; a clear suppresses both strobes.
        cnt_en_nxt     = tick_tc && state == ST_RUN && state_nxt == ST_RUN && !rst_evt;
        adj_we_nxt     = adj_tc && state == ST_ADJUST && state_nxt == ST_ADJUST && !rst_evt;
        cnt_clr_nxt    = rst_evt;
        adj_sel_nxt    = sel_s;
        adj_val_nxt    = clamp_digit(sel_s, num_s);
        blink_mask_nxt = (state == ST_ADJUST && blink_phase) ? one_hot(sel_s) : 4'b0000;
    end

    // ---- output register stage ----
    always_ff @(posedge clk_c) begin
        if (reset_c) begin
            state      <= ST_RUN;
            resume_run <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            adj_we     <= 1'b0;
            adj_sel    <= 2'b00;
            adj_val    <= 4'b0000;
            blink_mask <= 4'b0000;
        end else begin
            state      <= state_nxt;
            resume_run <= resume_nxt;
            cnt_en     <= cnt_en_nxt;
            cnt_clr    <= cnt_clr_nxt;
            adj_we     <= adj_we_nxt;
            adj_sel    <= adj_sel_nxt;
            adj_val    <= adj_val_nxt;
            blink_mask <= blink_mask_nxt;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with small dividers. A reference model keyed
// on the absolute cycle number predicts every registered output; scenario
// tasks add directed latency and boundary checks on top.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int ADJ_DIV   = 4;
    localparam int BLINK_DIV = 2;
    localparam int DB_CYC    = 3;

    localparam logic [1:0] M_RUN    = 2'b00;
    localparam logic [1:0] M_PAUSED = 2'b01;
    localparam logic [1:0] M_ADJ    = 2'b10;

    logic       clk_c = 1'b0;
    logic       reset_c = 1'b0;
    logic       btn_pause = 1'b0, btn_rst = 1'b0, ADJ = 1'b0;
    logic [1:0] SEL = 2'b00;
    logic [3:0] NUM = 4'b0000;
    logic       cnt_en, cnt_clr, adj_we;
    logic [1:0] adj_sel, mode;
    logic [3:0] adj_val, blink_mask;

    stopwatch_ctrl #(
        .TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV), .BLINK_DIV(BLINK_DIV), .DB_CYC(DB_CYC)
    ) dut (
        .clk_c(clk_c), .reset_c(reset_c), .btn_pause(btn_pause), .btn_rst(btn_rst),
        .ADJ(ADJ), .SEL(SEL), .NUM(NUM), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .adj_we(adj_we), .adj_sel(adj_sel), .adj_val(adj_val),
        .blink_mask(blink_mask), .mode(mode)
    );

    always #5 clk_c = ~clk_c;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // n counts clock edges since the last reset edge; raw_h[n] holds the raw
    // inputs sampled at edge n. The synchronized view during cycle k is raw_h[k-1].
    int         n = 0;
    logic [8:0] raw_h [0:16383];
    logic [1:0] m_mode = M_RUN;
    logic       m_resume = 1'b0;
    logic       a_pause = 1'b0, a_pause_d = 1'b0, a_rst = 1'b0, a_rst_d = 1'b0;
    int         run_start = 0, adj_start = 0;
    logic       e_cnt_en = 0, e_cnt_clr = 0, e_adj_we = 0;
    logic [1:0] e_adj_sel = 0;
    logic [3:0] e_adj_val = 0, e_blink = 0;

    function automatic logic [8:0] rawat(input int i);
        return (i < 1) ? 9'd0 : raw_h[i];
    endfunction

    function automatic logic [3:0] ref_clamp(input logic [1:0] s, input logic [3:0] v);
        int lim;
        lim = (s == 2'b01 || s == 2'b11) ? 5 : 9;
        return (int'(v) > lim) ? 4'(lim) : v;
    endfunction

    function automatic logic [14:0] dut_vec();
        return {cnt_en, cnt_clr, adj_we, adj_sel, adj_val, blink_mask, mode};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {e_cnt_en, e_cnt_clr, e_adj_we, e_adj_sel, e_adj_val, e_blink, m_mode};
    endfunction

    task automatic model_edge();
        logic [8:0] s, t;
        logic       pe, re, leaving, flip_p, flip_r;
        logic [1:0] old_m, new_m;
        if (reset_c) begin
            n = 0; m_mode = M_RUN; m_resume = 1'b0;
            a_pause = 0; a_pause_d = 0; a_rst = 0; a_rst_d = 0;
            run_start = 0; adj_start = 0;
            e_cnt_en = 0; e_cnt_clr = 0; e_adj_we = 0; e_adj_sel = 0; e_adj_val = 0; e_blink = 0;
            return;
        end
        n++;
        raw_h[n] = {btn_pause, btn_rst, ADJ, SEL, NUM};
        s  = rawat(n - 2);
        pe = a_pause & ~a_pause_d;
        re = a_rst & ~a_rst_d;
        old_m = m_mode;
        new_m = old_m;
        case (old_m)
            M_RUN:    if (s[6]) begin new_m = M_ADJ; m_resume = 1'b1 ^ pe; end
                      else if (pe) new_m = M_PAUSED;
            M_PAUSED: if (s[6]) begin new_m = M_ADJ; m_resume = 1'b0 ^ pe; end
                      else if (pe) new_m = M_RUN;
            default:  if (!s[6]) new_m = m_resume ? M_RUN : M_PAUSED;
                      else if (pe) m_resume = ~m_resume;
        endcase
        leaving   = (new_m != old_m);
        e_cnt_en  = (old_m == M_RUN) && !leaving && !re && ((n - run_start) % TICK_DIV == 0);
        e_adj_we  = (old_m == M_ADJ) && !leaving && !re && ((n - adj_start) % ADJ_DIV == 0);
        e_cnt_clr = re;
        e_adj_sel = s[5:4];
        e_adj_val = ref_clamp(s[5:4], s[3:0]);
        e_blink   = (old_m == M_ADJ && ((n - 1) / BLINK_DIV) % 2 == 1) ? (4'b0001 << s[5:4]) : 4'b0000;
        if (new_m == M_RUN && (old_m != M_RUN || re)) run_start = n;
        if (new_m == M_ADJ && old_m != M_ADJ)         adj_start = n;
        m_mode = new_m;
        // accepted level flips once the last DB_CYC synchronized samples all disagree with it
        flip_p = 1'b1; flip_r = 1'b1;
        for (int k = 1; k <= DB_CYC; k++) begin
            t = rawat(n - k - 1);
            if (t[8] == a_pause) flip_p = 1'b0;
            if (t[7] == a_rst)   flip_r = 1'b0;
        end
        a_pause_d = a_pause;
        a_rst_d   = a_rst;
        if (flip_p) a_pause = ~a_pause;
        if (flip_r) a_rst   = ~a_rst;
    endtask

    // Advance one clock: inputs were driven on the falling edge, the model
    // follows the rising edge, and outputs are observed on the next falling edge.
    task automatic tick();
        @(posedge clk_c);
        model_edge();
        @(negedge clk_c);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_c = 1'b1;
        tick(); tick();
        reset_c = 1'b0;
        n_tests++;
        if (dut_vec() !== 15'd0) begin
            n_fail++; $display("FAIL reset_state got %h exp %h", dut_vec(), 15'd0);
        end
    endtask

    task automatic test_idle_run();
        int pulses = 0;
        int other  = 0;
        for (int c = 0; c < 35; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL idle_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (cnt_en) pulses++;
            if (cnt_clr || adj_we || blink_mask != 0 || mode != M_RUN) other++;
        end
        n_tests++;
        if (pulses !== 3) begin n_fail++; $display("FAIL idle_pulses got %0d exp 3", pulses); end
        n_tests++;
        if (other !== 0) begin n_fail++; $display("FAIL idle_quiet got %0d exp 0", other); end
    endtask

    task automatic test_pause_bounce();
        logic [1:0] prev_m;
        int trans = 0, lat = 0, en_after = 0;
        logic [3:0] pat;
        pat = 4'b0101;  // 1,0,1,0 one-cycle glitches, applied LSB first
        prev_m = mode;
        for (int c = 0; c < 4; c++) begin
            btn_pause = pat[c];
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (mode != prev_m) trans++;
            prev_m = mode;
        end
        btn_pause = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pause_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (mode != prev_m) trans++;
            if (mode == M_PAUSED && lat == 0) lat = c;
            else if (lat != 0 && cnt_en) en_after++;
            prev_m = mode;
        end
        btn_pause = 1'b0;
        for (int c = 0; c < DB_CYC + 6; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL release_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (mode != prev_m) trans++;
            prev_m = mode;
        end
        n_tests++;
        if (lat !== DB_CYC + 3) begin n_fail++; $display("FAIL pause_latency got %0d exp %0d", lat, DB_CYC + 3); end
        n_tests++;
        if (trans !== 1) begin n_fail++; $display("FAIL pause_transitions got %0d exp 1", trans); end
        n_tests++;
        if (en_after !== 0 || mode !== M_PAUSED) begin
            n_fail++; $display("FAIL paused_hold got en=%0d mode=%0d exp en=0 mode=1", en_after, mode);
        end
    endtask

    task automatic test_adjust();
        int we_ok = 0, we_cnt = 0, blink_on = 0, blink_bad = 0;
        ADJ = 1'b1; SEL = 2'b01; NUM = 4'd8;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL adj_entry_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (mode !== M_ADJ) begin n_fail++; $display("FAIL adj_entry_mode got %0d exp 2", mode); end
        for (int c = 1; c <= 16; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL adj_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (adj_we) begin
                we_cnt++;
                if (c % ADJ_DIV == 0 && adj_sel == 2'b01 && adj_val == 4'd5) we_ok++;
            end
            if (blink_mask == 4'b0010) blink_on++;
            else if (blink_mask != 4'b0000) blink_bad++;
        end
        n_tests++;
        if (we_cnt !== 4 || we_ok !== 4) begin
            n_fail++; $display("FAIL adj_we_pulses got %0d/%0d exp 4/4", we_ok, we_cnt);
        end
        n_tests++;
        if (blink_on !== 8 || blink_bad !== 0) begin
            n_fail++; $display("FAIL adj_blink got on=%0d bad=%0d exp on=8 bad=0", blink_on, blink_bad);
        end
        for (int r = 0; r < 8; r++) begin
            SEL = 2'($urandom_range(0, 3));
            NUM = 4'($urandom_range(0, 15));
            for (int c = 0; c < 7; c++) begin
                tick();
                n_tests++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL adj_rand_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_resume();
        int gap = 0;
        btn_pause = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL resume_press_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
        end
        btn_pause = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        ADJ = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        n_tests++;
        if (mode !== M_RUN) begin n_fail++; $display("FAIL resume_mode got %0d exp 0", mode); end
        for (int c = 1; c <= 20 && gap == 0; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL resume_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (cnt_en) gap = c;
        end
        n_tests++;
        if (gap !== TICK_DIV) begin n_fail++; $display("FAIL resume_first_tick got %0d exp %0d", gap, TICK_DIV); end
    endtask

    task automatic test_clear_on_tick();
        int found = 0, gap = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (cnt_en) found = 1;
        end
        n_tests++;
        if (found !== 1) begin n_fail++; $display("FAIL clear_sync got %0d exp 1", found); end
        for (int c = 0; c < 4; c++) tick();
        btn_rst = 1'b1;
        for (int c = 0; c < DB_CYC + 3; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL clear_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (cnt_clr !== 1'b1 || cnt_en !== 1'b0 || mode !== M_RUN) begin
            n_fail++; $display("FAIL clear_on_tick got clr=%0d en=%0d mode=%0d exp clr=1 en=0 mode=0",
                               cnt_clr, cnt_en, mode);
        end
        for (int c = 1; c <= 20 && gap == 0; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL clear_after_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (cnt_en) gap = c;
        end
        n_tests++;
        if (gap !== TICK_DIV) begin n_fail++; $display("FAIL clear_next_tick got %0d exp %0d", gap, TICK_DIV); end
        btn_rst = 1'b0;
        for (int c = 0; c < DB_CYC + 4; c++) tick();
    endtask

    task automatic test_reset_in_adjust();
        int found = 0;
        ADJ = 1'b1; SEL = 2'b10; NUM = 4'($urandom_range(0, 15));
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rst_adj_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
            end
            if (blink_mask == 4'b0100) found = 1;
        end
        n_tests++;
        if (found !== 1) begin n_fail++; $display("FAIL rst_adj_blink_wait got %0d exp 1", found); end
        reset_c = 1'b1; ADJ = 1'b0;
        tick();
        reset_c = 1'b0;
        n_tests++;
        if (mode !== M_RUN || blink_mask !== 4'b0000 || adj_we !== 1'b0) begin
            n_fail++; $display("FAIL rst_adj_outputs got mode=%0d mask=%b we=%0d exp mode=0 mask=0000 we=0",
                               mode, blink_mask, adj_we);
        end
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rst_adj_model_after got %h exp %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 70; seg++) begin
            btn_pause = 1'($urandom_range(0, 1));
            btn_rst   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) ADJ = ~ADJ;
            SEL = 2'($urandom_range(0, 3));
            NUM = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                tick();
                n_tests++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++; $display("FAIL random_model cyc %0d got %h exp %h", n, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        @(negedge clk_c);
        test_reset();
        test_idle_run();
        test_pause_bounce();
        test_adjust();
        test_resume();
        test_clear_on_tick();
        test_reset_in_adjust();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the mm:ss stopwatch digit counter. Conditions the raw pause/reset buttons and the ADJ/SEL/NUM switches, and generates the 1 Hz count enable, the 2 Hz adjust-write strobes and the digit blink mask. It runs the RUN/PAUSED/ADJUST mode state machine so the digit datapath only sees clean single-cycle commands. Sits between the board I/O and the digit counter, alongside the 7-segment driver that consumes `blink_mask`.

## Interface
- `TICK_DIV`, default 100_000_000: clk_c cycles per count tick (1 Hz).
- `ADJ_DIV`, default 50_000_000: clk_c cycles per adjust write (2 Hz).
- `BLINK_DIV`, default 25_000_000: clk_c cycles per blink phase toggle.
- `DB_CYC`, default 1_000_000: consecutive stable cycles to accept a button level.
- `clk_c` in 1: single clock; all logic on its rising edge.
- `reset_c` in 1: synchronous, active-high reset.
- `btn_pause` in 1: raw pause button, asynchronous, bouncy.
- `btn_rst` in 1: raw clear button, asynchronous, bouncy.
- `ADJ` in 1: adjust-mode switch, asynchronous.
- `SEL` in 2: digit select; 00 sec_ones, 01 sec_tens, 10 min_ones, 11 min_tens.
- `NUM` in 4: value to load into the selected digit.
- `cnt_en` out 1: one-cycle pulse; counter advances one second.
- `cnt_clr` out 1: one-cycle pulse; counter clears to 00:00.
- `adj_we` out 1: one-cycle write strobe for the selected digit.
- `adj_sel` out 2: digit index qualified by `adj_we`.
- `adj_val` out 4: clamped digit value qualified by `adj_we`.
- `blink_mask` out 4: bit i set means digit i is blanked this phase.
- `mode` out 2: 00 RUN, 01 PAUSED, 10 ADJUST.

## Operation
- Input conditioning:
  - `btn_pause`, `btn_rst`, `ADJ`, `SEL` and `NUM` each pass through a 2-flop synchronizer.
  - Each button has a debouncer. The accepted level changes only after the synchronized level differs from it for `DB_CYC` consecutive cycles.
  - A rising edge of the accepted level produces an internal one-cycle event (`pause_evt`, `rst_evt`).
- Dividers:
  - The tick counter counts 0..`TICK_DIV`-1 only in RUN and fires at terminal count.
  - It is forced to 0 in any other mode and on `rst_evt`, so the first tick after resume or clear comes exactly `TICK_DIV` cycles later.
  - The adjust counter counts 0..`ADJ_DIV`-1 only in ADJUST and is zeroed on entry.
  - The blink counter is free-running and toggles `blink_phase` at terminal count.
- FSM states: RUN, PAUSED, ADJUST, plus a `resume_run` flag.
  - RUN: `ADJ`=1 sets `resume_run`=1 and goes to ADJUST. Otherwise `pause_evt` goes to PAUSED.
  - PAUSED: `ADJ`=1 sets `resume_run`=0 and goes to ADJUST. Otherwise `pause_evt` goes to RUN.
  - ADJUST: `pause_evt` toggles `resume_run`. `ADJ`=0 goes to RUN if `resume_run`=1, else to PAUSED.
  - `ADJ` takes priority over `pause_evt`. A `pause_evt` in the entry cycle toggles the just-saved `resume_run`.
- Outputs:
  - `cnt_en` = tick fire AND mode RUN.
  - `cnt_clr` = `rst_evt` in any mode; the mode is unchanged.
  - `cnt_clr` overrides `cnt_en` and `adj_we` in the same cycle; those are suppressed.
  - `adj_we` = adjust terminal count in ADJUST. `adj_sel` = synchronized `SEL`.
  - `adj_val` = synchronized `NUM`, clamped to 9 for `SEL` 00/10 and to 5 for `SEL` 01/11.
  - `blink_mask` = one-hot(`SEL`) when mode is ADJUST and `blink_phase`=1; otherwise 0000.
- Reset: mode RUN, `resume_run`=0, all counters 0, debounced levels 0, `blink_phase`=0. Outputs reset to `cnt_en`=0, `cnt_clr`=0, `adj_we`=0, `adj_sel`=00, `adj_val`=0000, `blink_mask`=0000, `mode`=00.

## Timing
- All outputs are registered: one cycle after the internal condition.
- Button latency: a clean raw press held from cycle 0 gives `cnt_clr` (or the mode change) visible at cycle `DB_CYC`+3. Bounces shorter than `DB_CYC` produce no event.
- Holding a button produces exactly one event; release produces none.
- `ADJ` latency: raw change at cycle 0 gives `mode` updated at cycle 3. No debounce is applied to switches.
- In RUN, `cnt_en` pulses exactly every `TICK_DIV` cycles.
- In ADJUST, `adj_we` pulses exactly every `ADJ_DIV` cycles, first pulse `ADJ_DIV` cycles after entry.
- `SEL`/`NUM` changes are reflected in the next `adj_we` and in `blink_mask` 3 cycles after the raw change.
- `reset_c` mid-operation: state and outputs take reset values at the next edge. It overrides all events that cycle.
- Divider wrap: a terminal count in the same cycle as a mode exit does not emit its pulse.

## Test plan
Parameters: `TICK_DIV`=10, `ADJ_DIV`=4, `BLINK_DIV`=2, `DB_CYC`=3.
- Reset, then idle 35 cycles -> `mode`=00; `cnt_en` pulses at 10-cycle spacing; all other outputs stay 0.
- `btn_pause` bounces 1-0-1 (1-cycle glitches), then held -> exactly one transition to `mode`=01, `DB_CYC`+3 cycles after the stable edge; `cnt_en` stops.
- In PAUSED, `ADJ`=1 with `SEL`=01, `NUM`=8 -> `mode`=10; every 4 cycles `adj_we`=1 with `adj_sel`=01, `adj_val`=5; `blink_mask` alternates 0000/0010 every 2 cycles.
- In ADJUST, press pause, then `ADJ`=0 -> `mode`=00; first `cnt_en` exactly 10 cycles after mode change.
- In RUN, `btn_rst` press timed so `rst_evt` coincides with a tick -> `cnt_clr`=1, `cnt_en`=0 that cycle; next `cnt_en` 10 cycles later.
- `reset_c` asserted one cycle while in ADJUST with `blink_mask`=0100 -> next edge `mode`=00, `blink_mask`=0000, `adj_we`=0.
